// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, branch condition codes, flag bit positions,
// and the per-opcode flag-write rules.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LHB    = 4'b1010,
    OP_LLB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NEQ  = 3'b000,
    CC_EQ   = 3'b001,
    CC_GT   = 3'b010,
    CC_LT   = 3'b011,
    CC_GTE  = 3'b100,
    CC_LTE  = 3'b101,
    CC_OVFL = 3'b110,
    CC_UNC  = 3'b111
  } cond_e;

  // Flag register layout is {Z,V,N}
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  function automatic logic op_writes_z(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_vn(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition resolution against a {Z,V,N} flag set.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       z_i,
  input  logic       v_i,
  input  logic       n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_NEQ:  taken_o = ~z_i;
      CC_EQ:   taken_o = z_i;
      CC_GT:   taken_o = ~z_i & ~n_i;
      CC_LT:   taken_o = n_i;
      CC_GTE:  taken_o = z_i | ~n_i;
      CC_LTE:  taken_o = n_i | z_i;
      CC_OVFL: taken_o = v_i;
      CC_UNC:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register with same-cycle bypass, branch target generation and a
// single-entry handshaked PC redirect register toward IF.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IMM_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_wr_en,
  input  logic [3:0]       alu_opcode,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_is_reg,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [PC_W-1:0]  br_rs,
  input  logic             flush,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [2:0]       flags
);

  typedef enum logic {ST_IDLE, ST_PEND} state_e;

  state_e            state_q, state_d;
  logic [2:0]        flags_q, flags_d;
  logic [PC_W-1:0]   rpc_q, rpc_d;
  logic [PC_W-1:0]   imm_ext, b_target, target;
  logic              taken, accept;

  // Merged flags: bits written this cycle come from the ALU, the rest from the register.
  always_comb begin
    flags_d = flags_q;
    if (flag_wr_en) begin
      if (op_writes_z(alu_opcode)) flags_d[FLAG_Z] = alu_z;
      if (op_writes_vn(alu_opcode)) begin
        flags_d[FLAG_V] = alu_v;
        flags_d[FLAG_N] = alu_n;
      end
    end
  end

  branch_cond_eval u_cond (
    .cond_i  (br_cond),
    .z_i     (flags_d[FLAG_Z]),
    .v_i     (flags_d[FLAG_V]),
    .n_i     (flags_d[FLAG_N]),
    .taken_o (taken)
  );

  assign imm_ext  = {{(PC_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
  assign b_target = br_pc + PC_W'(2) + {imm_ext[PC_W-2:0], 1'b0};
  assign target   = br_is_reg ? br_rs : b_target;

  assign redirect_valid = (state_q == ST_PEND);
  assign br_ready       = ~redirect_valid | redirect_ready;
  assign accept         = br_valid & br_ready & ~flush;
  assign redirect_pc    = rpc_q;
  assign flags          = flags_q;

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (accept && taken) begin
      state_d = ST_PEND;
      rpc_d   = {target[PC_W-1:1], 1'b0};
    end else if (state_q == ST_PEND && redirect_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rpc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: flag writes, bypass, targets, handshake, flush, reset.
module tb_flag_branch_unit;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned IMM_W = 9;

  logic             clk;
  logic             rst_n;
  logic             flag_wr_en;
  logic [3:0]       alu_opcode;
  logic             alu_z, alu_v, alu_n;
  logic             br_valid;
  logic             br_ready;
  logic             br_is_reg;
  logic [2:0]       br_cond;
  logic [PC_W-1:0]  br_pc;
  logic [IMM_W-1:0] br_imm;
  logic [PC_W-1:0]  br_rs;
  logic             flush;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [PC_W-1:0]  redirect_pc;
  logic [2:0]       flags;

  int tests  = 0;
  int failed = 0;

  flag_branch_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flag_wr_en     (flag_wr_en),
    .alu_opcode     (alu_opcode),
    .alu_z          (alu_z),
    .alu_v          (alu_v),
    .alu_n          (alu_n),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_is_reg      (br_is_reg),
    .br_cond        (br_cond),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .br_rs          (br_rs),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flags          (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_wr_en = 1'b0; alu_opcode = 4'h0; alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
    br_valid = 1'b0; br_is_reg = 1'b0; br_cond = 3'b000; br_pc = '0; br_imm = '0;
    br_rs = '0; flush = 1'b0; redirect_ready = 1'b0;
  endtask

  // Offer B with every condition against the current flags; exp bit c = cond c taken.
  task automatic sweep(input string tag, input logic [7:0] exp);
    for (int c = 0; c < 8; c++) begin
      br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'(c);
      br_pc = 16'h0200; br_imm = 9'(c); redirect_ready = 1'b1;
      tick();
      chk($sformatf("%s_c%0d_valid", tag, c), 32'(redirect_valid), 32'(exp[c]));
      if (exp[c]) chk($sformatf("%s_c%0d_pc", tag, c), 32'(redirect_pc), 32'(16'h0202 + 16'(2*c)));
    end
    br_valid = 1'b0;
    tick();
    chk({tag, "_drain"}, 32'(redirect_valid), 32'd0);
    redirect_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_valid", 32'(redirect_valid), 32'd0);
    chk("rst_pc", 32'(redirect_pc), 32'd0);
    chk("rst_ready", 32'(br_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    sweep("flags000", 8'b1001_0101);

    // SUB 5-5 then B EQ pc=0x0010 imm=+3
    flag_wr_en = 1'b1; alu_opcode = 4'b0001; alu_z = 1'b1; alu_v = 1'b0; alu_n = 1'b0;
    tick();
    chk("sub_flags", 32'(flags), 32'b100);
    chk("sub_noredir", 32'(redirect_valid), 32'd0);
    flag_wr_en = 1'b0;
    br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'b001; br_pc = 16'h0010; br_imm = 9'd3;
    tick();
    chk("beq_valid", 32'(redirect_valid), 32'd1);
    chk("beq_pc", 32'(redirect_pc), 32'h0018);
    br_valid = 1'b0; redirect_ready = 1'b1;
    tick();
    chk("beq_consumed", 32'(redirect_valid), 32'd0);
    redirect_ready = 1'b0;

    // Same-cycle ADD writing N=1 with B LT: only the bypassed flags make it taken
    flag_wr_en = 1'b1; alu_opcode = 4'b0000; alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b1;
    br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'b011; br_pc = 16'h0100; br_imm = 9'h1FC;
    tick();
    chk("bypass_flags", 32'(flags), 32'b001);
    chk("bypass_valid", 32'(redirect_valid), 32'd1);
    chk("bypass_pc", 32'(redirect_pc), 32'h00FA);
    flag_wr_en = 1'b0; br_valid = 1'b0; redirect_ready = 1'b1;
    tick();
    chk("bypass_consumed", 32'(redirect_valid), 32'd0);
    redirect_ready = 1'b0;

    sweep("flags001", 8'b1010_1001);

    // Opcodes that write nothing, and a disabled write, leave flags alone
    flag_wr_en = 1'b1; alu_opcode = 4'b1000; alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b0;
    tick();
    chk("lw_nowrite", 32'(flags), 32'b001);
    flag_wr_en = 1'b0; alu_opcode = 4'b0000;
    tick();
    chk("wren0_nowrite", 32'(flags), 32'b001);

    // V=1 via ADD, then XOR writes Z only
    flag_wr_en = 1'b1; alu_opcode = 4'b0000; alu_z = 1'b0; alu_v = 1'b1; alu_n = 1'b0;
    tick();
    chk("add_v", 32'(flags), 32'b010);
    alu_opcode = 4'b0010; alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b1;
    tick();
    chk("xor_holds_vn", 32'(flags), 32'b010);
    alu_opcode = 4'b0110; alu_z = 1'b1; alu_v = 1'b0; alu_n = 1'b1;
    tick();
    chk("ror_z_only", 32'(flags), 32'b110);
    alu_opcode = 4'b0010; alu_z = 1'b0;
    tick();
    chk("xor_clear_z", 32'(flags), 32'b010);
    flag_wr_en = 1'b0;

    // Not-taken branch: EQ with Z=0
    br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'b001; br_pc = 16'h0040; br_imm = 9'd1;
    tick();
    chk("nt_valid", 32'(redirect_valid), 32'd0);
    chk("nt_ready", 32'(br_ready), 32'd1);

    // B OVFL at 0xFFFE wraps to 0x0000
    br_cond = 3'b110; br_pc = 16'hFFFE; br_imm = 9'd0;
    tick();
    chk("ovfl_valid", 32'(redirect_valid), 32'd1);
    chk("ovfl_wrap_pc", 32'(redirect_pc), 32'h0000);
    br_valid = 1'b0; redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // BR unconditional, odd register target, held with redirect_ready=0
    br_valid = 1'b1; br_is_reg = 1'b1; br_cond = 3'b111; br_rs = 16'h1235;
    tick();
    chk("br_valid", 32'(redirect_valid), 32'd1);
    chk("br_pc_align", 32'(redirect_pc), 32'h1234);
    br_rs = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d_ready", i), 32'(br_ready), 32'd0);
      tick();
      chk($sformatf("hold%0d_valid", i), 32'(redirect_valid), 32'd1);
      chk($sformatf("hold%0d_pc", i), 32'(redirect_pc), 32'h1234);
    end

    // Back-to-back: consume and accept a new taken branch in the same cycle
    br_rs = 16'h2000; redirect_ready = 1'b1;
    #1;
    chk("b2b_ready", 32'(br_ready), 32'd1);
    tick();
    chk("b2b_valid", 32'(redirect_valid), 32'd1);
    chk("b2b_pc", 32'(redirect_pc), 32'h2000);

    // Flush with redirect pending and a branch offered; flags still update
    br_rs = 16'h5000; redirect_ready = 1'b0; flush = 1'b1;
    flag_wr_en = 1'b1; alu_opcode = 4'b0001; alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
    tick();
    chk("flush_valid", 32'(redirect_valid), 32'd0);
    chk("flush_flags", 32'(flags), 32'b111);
    flush = 1'b0; flag_wr_en = 1'b0; br_valid = 1'b0;
    tick();
    chk("flush_dropped", 32'(redirect_valid), 32'd0);

    sweep("flags111", 8'b1111_1010);

    // Async reset while a redirect is pending
    br_valid = 1'b1; br_is_reg = 1'b1; br_cond = 3'b111; br_rs = 16'h6000;
    tick();
    chk("prerst_valid", 32'(redirect_valid), 32'd1);
    br_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(redirect_valid), 32'd0);
    chk("arst_pc", 32'(redirect_pc), 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    chk("arst_ready", 32'(br_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", 32'(redirect_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
